mem_port_arbiter: RTL and testbench

Shares the single-port unified RAM between the FETCH stage (instruction reads) and the MEM stage (data reads/writes). It arbitrates one transaction at a time and sequences the fixed-latency RAM access. It returns read data with a one-cycle ready pulse and drives per-requester stall signals to the pipeline control. It sits between `FETCH`/`MEM` and the RAM instance inside `Mips`.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port RAM between FETCH and MEM, one fixed-latency
// transaction at a time, with MEM priority and a bounded FETCH starvation window.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RAM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            if_req,
    input  logic [ADDR_W-1:0]               if_addr,
    output logic [DATA_W-1:0]               if_rdata,
    output logic                            if_ready,
    output logic                            if_stall,
    input  logic                            mem_req,
    input  logic                            mem_we,
    input  logic [ADDR_W-1:0]               mem_addr,
    input  logic [DATA_W-1:0]               mem_wdata,
    output logic [DATA_W-1:0]               mem_rdata,
    output logic                            mem_ready,
    output logic                            mem_stall,
    output logic                            ram_en,
    output logic                            ram_we,
    output logic [ADDR_W-1:0]               ram_addr,
    output logic [DATA_W-1:0]               ram_wdata,
    input  logic [DATA_W-1:0]               ram_rdata,
    output logic [1:0]                      dbg_state,
    output logic [$clog2(MAX_WAIT+1)-1:0]   dbg_wait_cnt
);
    // Handshake: a requester raises req with its operands and holds them until
    // its ready pulse; the arbiter samples req only while IDLE and owns the
    // transaction from grant to the single RESP cycle, regardless of req.

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam int LCW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
    localparam logic [LCW-1:0] LAT_LAST = LCW'(RAM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [WCW-1:0]   wait_cnt;
    logic [LCW-1:0]   lat_cnt;
    logic             owner_mem;
    logic             we_q;
    logic             grant_if;
    logic             grant_mem;

    // FETCH wins only when MEM is absent or FETCH has waited out its window.
    always_comb begin
        grant_if  = if_req && (!mem_req || (wait_cnt == WAIT_MAX));
        grant_mem = mem_req && !grant_if;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_cnt   <= '0;
            owner_mem <= 1'b0;
            we_q      <= 1'b0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if || grant_mem) begin
                        state     <= BUSY;
                        lat_cnt   <= '0;
                        owner_mem <= grant_mem;
                        we_q      <= grant_mem && mem_we;
                        ram_en    <= 1'b1;
                        ram_we    <= grant_mem && mem_we;
                        ram_addr  <= grant_mem ? mem_addr : if_addr;
                        if (grant_mem) ram_wdata <= mem_wdata;
                        if (grant_if)
                            wait_cnt <= '0;
                        else if (if_req && (wait_cnt != WAIT_MAX))
                            wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                BUSY: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= RESP;
                        if (!we_q) begin
                            if (owner_mem) mem_rdata <= ram_rdata;
                            else           if_rdata  <= ram_rdata;
                        end
                        if (owner_mem) mem_ready <= 1'b1;
                        else           if_ready  <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + LCW'(1);
                    end
                end
                RESP: begin
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign if_stall     = if_req & ~if_ready;
    assign mem_stall    = mem_req & ~mem_ready;
    assign dbg_state    = state;
    assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level timing model and a response scoreboard.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int MW  = 4;
    localparam int WCW = $clog2(MW + 1);

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [AW-1:0]   if_addr = '0, mem_addr = '0;
    logic [DW-1:0]   mem_wdata = '0, ram_rdata = '0;
    logic [DW-1:0]   if_rdata, mem_rdata, ram_wdata;
    logic [AW-1:0]   ram_addr;
    logic            if_ready, if_stall, mem_ready, mem_stall, ram_en, ram_we;
    logic [1:0]      dbg_state;
    logic [WCW-1:0]  dbg_wait_cnt;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_stall(mem_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
    );

    // clock / reset
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // next-cycle driver values
    logic          nx_if_req = 0, nx_mem_req = 0, nx_mem_we = 0, nx_rd_forced = 0;
    logic [AW-1:0] nx_if_addr = '0, nx_mem_addr = '0;
    logic [DW-1:0] nx_mem_wdata = '0, nx_rd = '0;

    // transaction-level model: one transaction granted in cycle g occupies
    // g+1..g+LAT (RAM access) and g+LAT+1 (response); arbiter free again at g+LAT+2
    int            g = -1;
    int            idle_at = 0;
    int            wcnt = 0;
    logic          own_mem = 0, t_we = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_if_rd = '0, e_mem_rd = '0;
    logic [DW:0]   exp_q[$];

    task automatic model_step();
        int   n, st;
        logic in_resp, e_en, gi, gm;
        logic [DW:0] ent;
        n       = cyc;
        in_resp = (g >= 0) && (n == g + LAT + 1);
        e_en    = (g >= 0) && (n == g + 1);
        st      = (n >= idle_at) ? 0 : (in_resp ? 2 : 1);
        check("if_ready",  if_ready,  in_resp && !own_mem);
        check("mem_ready", mem_ready, in_resp && own_mem);
        check("if_stall",  if_stall,  if_req && !(in_resp && !own_mem));
        check("mem_stall", mem_stall, mem_req && !(in_resp && own_mem));
        check("ram_en",    ram_en,    e_en);
        check("ram_we",    ram_we,    e_en && t_we);
        check("ram_addr",  ram_addr,  e_addr);
        check("ram_wdata", ram_wdata, e_wdata);
        check("if_rdata",  if_rdata,  e_if_rd);
        check("mem_rdata", mem_rdata, e_mem_rd);
        check("state",     dbg_state, st);
        check("wait_cnt",  dbg_wait_cnt, wcnt);
        // scoreboard: every ready pulse consumes one expected response
        if (if_ready || mem_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_unexpected cyc=%0d got=ready want=none", cyc);
            end else begin
                ent = exp_q.pop_front();
                check("sb_owner", mem_ready, ent[DW]);
                check("sb_rdata", mem_ready ? mem_rdata : if_rdata, ent[DW-1:0]);
            end
        end
        if ((g >= 0) && (n == g + LAT)) begin
            if (!t_we) begin
                if (own_mem) e_mem_rd = ram_rdata;
                else         e_if_rd  = ram_rdata;
            end
            exp_q.push_back({own_mem, own_mem ? e_mem_rd : e_if_rd});
        end
        if (n >= idle_at) begin
            gi = if_req && (!mem_req || wcnt == MW);
            gm = mem_req && !gi;
            if (gi || gm) begin
                g       = n;
                idle_at = n + LAT + 2;
                own_mem = gm;
                t_we    = gm && mem_we;
                e_addr  = gm ? mem_addr : if_addr;
                if (gm) e_wdata = mem_wdata;
                if (gi)          wcnt = 0;
                else if (if_req) wcnt = (wcnt < MW) ? wcnt + 1 : MW;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if_req    = nx_if_req;
        if_addr   = nx_if_addr;
        mem_req   = nx_mem_req;
        mem_we    = nx_mem_we;
        mem_addr  = nx_mem_addr;
        mem_wdata = nx_mem_wdata;
        ram_rdata = nx_rd_forced ? nx_rd : $urandom();
        @(negedge clock);
        model_step();
    endtask

    // asserts reset between edges, checks the immediate effect, releases it a cycle later
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_if_ready", if_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_if_stall", if_stall, if_req);
        check("rst_mem_stall", mem_stall, mem_req);
        check("rst_state", dbg_state, 0);
        check("rst_wait", dbg_wait_cnt, 0);
        @(posedge clock);
        #1;
        cyc++;
        reset = 1'b0;
        nx_if_req = 0; nx_mem_req = 0; nx_mem_we = 0;
        if_req = 0; mem_req = 0; mem_we = 0;
        g = -1; idle_at = 0; wcnt = 0; own_mem = 0; t_we = 0;
        e_addr = '0; e_wdata = '0; e_if_rd = '0; e_mem_rd = '0;
        exp_q.delete();
        @(negedge clock);
        model_step();
    endtask

    // random requesters: hold until ready, may drop req once granted
    logic if_pend = 0, if_drop = 0, mem_pend = 0, mem_drop = 0, no_new = 0;

    task automatic rand_drive();
        int   n;
        logic resp_prev, in_txn;
        n         = cyc + 1;
        resp_prev = (g >= 0) && (n - 1 == g + LAT + 1);
        in_txn    = (g >= 0) && (n > g) && (n <= g + LAT + 1);
        if (resp_prev && !own_mem) if_pend = 0;
        if (resp_prev && own_mem)  mem_pend = 0;
        if (!if_pend) begin
            if (!no_new && $urandom_range(0, 1) == 1) begin
                if_pend = 1; if_drop = 0;
                nx_if_addr = $urandom();
            end
        end else if (in_txn && !own_mem && $urandom_range(0, 3) == 0) begin
            if_drop = 1;
        end
        if (!mem_pend) begin
            if (!no_new && $urandom_range(0, 2) != 0) begin
                mem_pend = 1; mem_drop = 0;
                nx_mem_we    = ($urandom_range(0, 2) == 0);
                nx_mem_addr  = $urandom();
                nx_mem_wdata = $urandom();
            end
        end else if (in_txn && own_mem && $urandom_range(0, 3) == 0) begin
            mem_drop = 1;
        end
        nx_if_req  = if_pend && !if_drop;
        nx_mem_req = mem_pend && !mem_drop;
    endtask

    int mem_pulses, if_at, w16, w17, en_cnt;

    initial begin
        do_reset();

        // single FETCH read
        nx_if_req = 1; nx_if_addr = 32'h10;
        tick();
        check("t1_stall_c0", if_stall, 1);
        tick();
        check("t1_en_c1", ram_en, 1);
        check("t1_addr_c1", ram_addr, 32'h10);
        check("t1_we_c1", ram_we, 0);
        check("t1_stall_c1", if_stall, 1);
        nx_rd_forced = 1; nx_rd = 32'h2002_0005;
        tick();
        nx_rd_forced = 0;
        check("t1_stall_c2", if_stall, 1);
        tick();
        check("t1_ready_c3", if_ready, 1);
        check("t1_rdata_c3", if_rdata, 32'h2002_0005);
        check("t1_stall_c3", if_stall, 0);
        nx_if_req = 0;
        tick();

        // simultaneous reads: MEM first, then FETCH
        do_reset();
        nx_if_req = 1; nx_if_addr = 32'h40;
        nx_mem_req = 1; nx_mem_we = 0; nx_mem_addr = 32'h200;
        tick();
        tick();
        check("t2_wait_c1", dbg_wait_cnt, 1);
        tick();
        tick();
        check("t2_mready_c3", mem_ready, 1);
        check("t2_iready_c3", if_ready, 0);
        nx_mem_req = 0;
        tick();
        check("t2_wait_c4", dbg_wait_cnt, 1);
        tick();
        check("t2_wait_c5", dbg_wait_cnt, 0);
        tick();
        tick();
        check("t2_iready_c7", if_ready, 1);
        nx_if_req = 0;
        tick();

        // starvation: MEM held continuously
        do_reset();
        nx_if_req = 1; nx_if_addr = 32'h80;
        nx_mem_req = 1; nx_mem_we = 0; nx_mem_addr = 32'h300;
        mem_pulses = 0; if_at = -1; w16 = -1; w17 = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (mem_ready && if_at < 0) mem_pulses++;
            if (if_ready && if_at < 0) if_at = k;
            if (k == 16) w16 = int'(dbg_wait_cnt);
            if (k == 17) w17 = int'(dbg_wait_cnt);
        end
        check("t3_mem_wins", mem_pulses, 4);
        check("t3_if_ready_at", if_at, 19);
        check("t3_wait_sat", w16, 4);
        check("t3_wait_clr", w17, 0);
        nx_if_req = 0; nx_mem_req = 0;
        for (int k = 0; k < 6; k++) tick();

        // MEM write
        do_reset();
        nx_mem_req = 1; nx_mem_we = 1; nx_mem_addr = 32'h100; nx_mem_wdata = 32'hDEAD_BEEF;
        en_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) nx_mem_req = 0;
            tick();
            if (ram_en) en_cnt++;
            if (k == 1) begin
                check("t4_we", ram_we, 1);
                check("t4_addr", ram_addr, 32'h100);
                check("t4_wdata", ram_wdata, 32'hDEAD_BEEF);
            end
            if (k == 3) check("t4_ready_c3", mem_ready, 1);
        end
        check("t4_en_once", en_cnt, 1);
        check("t4_rdata_kept", mem_rdata, 0);
        nx_mem_we = 0;

        // reset during BUSY, then a fresh FETCH
        nx_if_req = 1; nx_if_addr = 32'h44;
        tick();
        tick();
        check("t5_en_busy", ram_en, 1);
        do_reset();
        nx_if_req = 1; nx_if_addr = 32'h48;
        for (int k = 0; k < 4; k++) tick();
        check("t5_after_rst_ready", if_ready, 1);
        nx_if_req = 0;
        tick();

        // random traffic
        if_pend = 0; mem_pend = 0; if_drop = 0; mem_drop = 0;
        for (int k = 0; k < 800; k++) begin
            rand_drive();
            tick();
        end
        no_new = 1;
        for (int k = 0; k < 12; k++) begin
            rand_drive();
            tick();
        end
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
